sys_ctrl_tx: RTL and testbench



---
 rtl/sys_ctrl_tx.sv | 153 +++++++++++++++
 tb/tb_sys_ctrl_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_tx.sv
// Transmit-side controller: serialises RF (1 byte) / ALU (2 bytes, LSB first) results into UART_TX.
// Latency: valid -> TX_D_VLD 2 cycles; backpressure via TX_BUSY, overflow is sticky in ovf.
// Optional one-deep pending slot enabled by SYS_CTRL_TX_PEND_EN.
module sys_ctrl_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_VALID,
    input  logic                     TX_BUSY,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     ctrl_busy,
    output logic                     ovf
);

    typedef enum logic [1:0] {IDLE, SEND, BUSY_HI, BUSY_LO} state_t;

`ifdef SYS_CTRL_TX_PEND_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    state_t                   r_state, w_state_nxt;
    logic [ALU_OUT_WIDTH-1:0] r_buf, w_buf_nxt;
    logic [1:0]               r_cnt, w_cnt_nxt;
    logic                     r_pend_vld, w_pend_vld_nxt;
    logic                     r_pend_alu, w_pend_alu_nxt;
    logic [ALU_OUT_WIDTH-1:0] r_pend_dat, w_pend_dat_nxt;
    logic [DATA_WIDTH-1:0]    r_tx_dat, w_tx_dat_nxt;
    logic                     r_tx_vld, w_tx_vld_nxt;
    logic                     r_busy;
    logic                     r_ovf, w_ovf_nxt;
    logic                     w_rf_extra, w_alu_extra;
    logic [ALU_OUT_WIDTH-1:0] w_rd_ext;

    assign w_rd_ext    = {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, RdData};
    // Results that cannot be started now: anything while active, or the ALU half of a tie.
    assign w_rf_extra  = RdData_Valid && (r_state != IDLE);
    assign w_alu_extra = OUT_VALID && ((r_state != IDLE) || RdData_Valid);

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_cnt_nxt      = r_cnt;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_alu_nxt = r_pend_alu;
        w_pend_dat_nxt = r_pend_dat;
        w_tx_dat_nxt   = r_tx_dat;
        w_tx_vld_nxt   = 1'b0;
        w_ovf_nxt      = r_ovf;

        case (r_state)
            IDLE: begin
                if (RdData_Valid) begin
                    w_buf_nxt   = w_rd_ext;
                    w_cnt_nxt   = 2'd1;
                    w_state_nxt = SEND;
                end else if (OUT_VALID) begin
                    w_buf_nxt   = ALU_OUT;
                    w_cnt_nxt   = 2'd2;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (!TX_BUSY) begin
                    w_tx_dat_nxt = r_buf[DATA_WIDTH-1:0];
                    w_tx_vld_nxt = 1'b1;
                    w_state_nxt  = BUSY_HI;
                end
            end
            BUSY_HI: begin
                if (TX_BUSY) begin
                    w_state_nxt = BUSY_LO;
                end
            end
            BUSY_LO: begin
                if (!TX_BUSY) begin
                    if (r_cnt > 2'd1) begin
                        w_buf_nxt   = r_buf >> DATA_WIDTH;
                        w_cnt_nxt   = r_cnt - 2'd1;
                        w_state_nxt = SEND;
                    end else if (PEND_EN && r_pend_vld) begin
                        w_buf_nxt      = r_pend_dat;
                        w_cnt_nxt      = r_pend_alu ? 2'd2 : 2'd1;
                        w_pend_vld_nxt = 1'b0;
                        w_state_nxt    = SEND;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Slot freed by the dequeue above may be refilled on the same edge.
        if (w_rf_extra) begin
            if (PEND_EN && !w_pend_vld_nxt) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_alu_nxt = 1'b0;
                w_pend_dat_nxt = w_rd_ext;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end
        if (w_alu_extra) begin
            if (PEND_EN && !w_pend_vld_nxt) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_alu_nxt = 1'b1;
                w_pend_dat_nxt = ALU_OUT;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_pend_alu <= 1'b0;
            r_pend_dat <= '0;
            r_tx_dat   <= '0;
            r_tx_vld   <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_alu <= w_pend_alu_nxt;
            r_pend_dat <= w_pend_dat_nxt;
            r_tx_dat   <= w_tx_dat_nxt;
            r_tx_vld   <= w_tx_vld_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign TX_P_DATA = r_tx_dat;
    assign TX_D_VLD  = r_tx_vld;
    assign ctrl_busy = r_busy;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Directed bench for sys_ctrl_tx with a UART_TX busy model (busy 10 cycles per strobe).
// Covers both builds of SYS_CTRL_TX_PEND_EN.
module tb_sys_ctrl_tx;

    logic        clk;
    logic        reset;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        TX_BUSY;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        ctrl_busy;
    logic        ovf;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          mdl_cnt = 0;
    logic        hold = 1'b0;
    logic        busy_smp = 1'b0;
    logic        prev_vld = 1'b0;
    int          t_valid = 0;
    int          t_idle = 0;
    int          t_rel = 0;
    logic [7:0]  q_dat[$];
    int          q_cyc[$];

    sys_ctrl_tx #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_OUT      (ALU_OUT),
        .OUT_VALID    (OUT_VALID),
        .TX_BUSY      (TX_BUSY),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .ctrl_busy    (ctrl_busy),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign TX_BUSY = (mdl_cnt != 0) || hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        busy_smp <= TX_BUSY;
    end

    // Strobe logger plus UART_TX busy model.
    always @(negedge clk) begin
        if (TX_D_VLD) begin
            chk("strobe_while_busy", {31'd0, busy_smp}, 32'd0);
            chk("strobe_back_to_back", {31'd0, prev_vld}, 32'd0);
            q_dat.push_back(TX_P_DATA);
            q_cyc.push_back(cyc);
        end
        prev_vld = TX_D_VLD;
        if (mdl_cnt > 0) mdl_cnt--;
        if (TX_D_VLD) mdl_cnt = 10;
    end

    task automatic pulse_rf(input logic [7:0] d);
        @(posedge clk); #1;
        RdData = d; RdData_Valid = 1'b1;
        @(posedge clk); #1;
        RdData_Valid = 1'b0;
        t_valid = cyc;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        @(posedge clk); #1;
        ALU_OUT = d; OUT_VALID = 1'b1;
        @(posedge clk); #1;
        OUT_VALID = 1'b0;
        t_valid = cyc;
    endtask

    task automatic wait_idle(input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!ctrl_busy) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_data", {24'd0, TX_P_DATA}, 32'd0);
        chk("rst_vld", {31'd0, TX_D_VLD}, 32'd0);
        chk("rst_busy", {31'd0, ctrl_busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        q_dat.delete();
        q_cyc.delete();
    endtask

    initial begin
        reset = 1'b0;
        RdData = 8'h00; RdData_Valid = 1'b0;
        ALU_OUT = 16'h0000; OUT_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, TX_P_DATA}, 32'd0);
        chk("rst_vld", {31'd0, TX_D_VLD}, 32'd0);
        chk("rst_busy", {31'd0, ctrl_busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        reset = 1'b1;

        // Single RF byte.
        pulse_rf(8'h5A);
        wait_idle(100, t_idle);
        chk("rf_count", q_dat.size(), 32'd1);
        chk("rf_data", {24'd0, q_dat[0]}, 32'h5A);
        chk("rf_latency", q_cyc[0] - t_valid, 32'd1);
        chk("rf_idle_time", t_idle - q_cyc[0], 32'd11);
        chk("rf_ovf", {31'd0, ovf}, 32'd0);
        chk("rf_hold_data", {24'd0, TX_P_DATA}, 32'h5A);

        // ALU result, LSB first.
        q_dat.delete(); q_cyc.delete();
        pulse_alu(16'h1234);
        wait_idle(100, t_idle);
        chk("alu_count", q_dat.size(), 32'd2);
        chk("alu_lo", {24'd0, q_dat[0]}, 32'h34);
        chk("alu_hi", {24'd0, q_dat[1]}, 32'h12);
        chk("alu_gap", q_cyc[1] - q_cyc[0], 32'd12);
        chk("alu_idle_time", t_idle - q_cyc[1], 32'd11);

        // Result arrives while UART is held busy.
        q_dat.delete(); q_cyc.delete();
        @(posedge clk); #1 hold = 1'b1;
        pulse_rf(8'h3C);
        repeat (20) @(posedge clk);
        chk("held_no_strobe", q_dat.size(), 32'd0);
        #1 hold = 1'b0;
        t_rel = cyc;
        wait_idle(100, t_idle);
        chk("held_count", q_dat.size(), 32'd1);
        chk("held_data", {24'd0, q_dat[0]}, 32'h3C);
        chk("held_release", q_cyc[0] - t_rel, 32'd1);

        // Simultaneous RF and ALU.
        q_dat.delete(); q_cyc.delete();
        @(posedge clk); #1;
        RdData = 8'hAA; RdData_Valid = 1'b1;
        ALU_OUT = 16'hBEEF; OUT_VALID = 1'b1;
        @(posedge clk); #1;
        RdData_Valid = 1'b0; OUT_VALID = 1'b0;
`ifdef SYS_CTRL_TX_PEND_EN
        chk("tie_ovf_edge", {31'd0, ovf}, 32'd0);
        wait_idle(200, t_idle);
        chk("tie_count", q_dat.size(), 32'd3);
        chk("tie_b0", {24'd0, q_dat[0]}, 32'hAA);
        chk("tie_b1", {24'd0, q_dat[1]}, 32'hEF);
        chk("tie_b2", {24'd0, q_dat[2]}, 32'hBE);
        chk("tie_ovf", {31'd0, ovf}, 32'd0);
`else
        chk("tie_ovf_edge", {31'd0, ovf}, 32'd1);
        wait_idle(200, t_idle);
        chk("tie_count", q_dat.size(), 32'd1);
        chk("tie_b0", {24'd0, q_dat[0]}, 32'hAA);
        chk("tie_ovf", {31'd0, ovf}, 32'd1);
`endif

        // Two ALU results during an RF send.
        do_reset();
        pulse_rf(8'h11);
        pulse_alu(16'h1234);
        pulse_alu(16'h5678);
        chk("two_alu_ovf", {31'd0, ovf}, 32'd1);
        wait_idle(200, t_idle);
`ifdef SYS_CTRL_TX_PEND_EN
        chk("two_alu_count", q_dat.size(), 32'd3);
        chk("two_alu_b0", {24'd0, q_dat[0]}, 32'h11);
        chk("two_alu_b1", {24'd0, q_dat[1]}, 32'h34);
        chk("two_alu_b2", {24'd0, q_dat[2]}, 32'h12);
        chk("pend_no_idle_gap", q_cyc[1] - q_cyc[0], 32'd12);
`else
        chk("two_alu_count", q_dat.size(), 32'd1);
        chk("two_alu_b0", {24'd0, q_dat[0]}, 32'h11);
`endif

        // Reset between the two bytes of an ALU message.
        do_reset();
        pulse_alu(16'h1234);
        for (int i = 0; i < 50 && q_dat.size() == 0; i++) @(negedge clk);
        chk("mid_first_strobe", q_dat.size(), 32'd1);
        repeat (3) @(posedge clk);
        do_reset();
        chk("mid_ovf_clear", {31'd0, ovf}, 32'd0);
        repeat (30) @(posedge clk);
        chk("mid_no_hi_byte", q_dat.size(), 32'd0);
        pulse_rf(8'h77);
        wait_idle(100, t_idle);
        chk("mid_next_count", q_dat.size(), 32'd1);
        chk("mid_next_data", {24'd0, q_dat[0]}, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
